// File: rtl/issue_ctrl_pkg.sv
// Shared types and defaults for the issue controller and its scoreboard.
package issue_ctrl_pkg;

    localparam int NUM_REGS_DEF     = 32;
    localparam int MAX_INFLIGHT_DEF = 4;
    localparam int REG_W            = 5;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-to-issue handshake bundle: decoded instruction fields plus the execute valid/ready pair.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic             dec_valid;
    logic             dec_ready;
    logic [REG_W-1:0] dec_rs1;
    logic [REG_W-1:0] dec_rs2;
    logic [REG_W-1:0] dec_rd;
    logic             dec_uses_rs1;
    logic             dec_uses_rs2;
    logic             dec_writes_rd;
    logic             dec_long;
    logic             dec_fence;
    logic             iss_valid;
    logic             iss_ready;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
        output dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_long, dec_fence,
        output iss_ready,
        input  dec_ready, iss_valid
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_long, dec_fence,
        input  iss_ready,
        output dec_ready, iss_valid
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Register busy bits, outstanding long-op counter and sticky underflow error.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_W-1:0]    set_rd,
    input  logic                clr_en,
    input  logic [REG_W-1:0]    clr_rd,
    input  logic                inc,
    input  logic                dec,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    inflight,
    output logic                err
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    // Clear is applied before set so a same-cycle set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (dec && (cnt_q == '0)) err_d = 1'b1;
        if (inc && !dec) begin
            if (cnt_q != CNT_W'(MAX_INFLIGHT)) cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign inflight = cnt_q;
    assign err      = err_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: holds decoded instructions until hazard-free, limits long ops in flight,
// and drains outstanding long ops before letting a fence through.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_ctrl_if.slave         bus,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    inflight,
    output logic [31:0]         stall_cnt,
    output logic                err
);

    issue_state_t state_q, state_d;
    logic [31:0]  stall_q, stall_d;
    logic         hazard, cap_block, iss_valid_c, fire, long_fire;

    assign hazard =
        (bus.dec_uses_rs1  && (bus.dec_rs1 != '0) && busy_vec[bus.dec_rs1]) ||
        (bus.dec_uses_rs2  && (bus.dec_rs2 != '0) && busy_vec[bus.dec_rs2]) ||
        (bus.dec_writes_rd && (bus.dec_rd  != '0) && busy_vec[bus.dec_rd]);

    assign cap_block = bus.dec_long && (inflight == CNT_W'(MAX_INFLIGHT));

    // Issue is gated by rst_n so nothing is offered while the block is held in reset.
    always_comb begin
        state_d     = state_q;
        iss_valid_c = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.dec_valid && bus.dec_fence && !flush) begin
                    if (inflight == '0) iss_valid_c = 1'b1;
                    else                state_d     = DRAIN;
                end else begin
                    iss_valid_c = bus.dec_valid && !hazard && !cap_block &&
                                  !flush && !bus.dec_fence;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = RUN;
                end else if (inflight == '0) begin
                    iss_valid_c = bus.dec_valid && bus.dec_fence;
                    if (iss_valid_c && bus.iss_ready) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        iss_valid_c = iss_valid_c && rst_n;
    end

    assign fire          = iss_valid_c && bus.iss_ready;
    assign long_fire     = fire && bus.dec_long;
    assign bus.iss_valid = iss_valid_c;
    assign bus.dec_ready = fire;

    always_comb begin
        stall_d = stall_q;
        if (bus.dec_valid && !fire && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    issue_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (long_fire && bus.dec_writes_rd && (bus.dec_rd != '0)),
        .set_rd   (bus.dec_rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .inc      (long_fire),
        .dec      (wb_valid),
        .busy_vec (busy_vec),
        .inflight (inflight),
        .err      (err)
    );

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized and directed bench for issue_ctrl against a queue-of-outstanding-ops model.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    typedef struct packed {
        logic       v, fn, lng, wr, u1, u2;
        logic [4:0] rs1, rs2, rd;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] busy_vec;
    logic [2:0]  inflight;
    logic [31:0] stall_cnt;
    logic        err;

    always #5 clk = ~clk;

    issue_ctrl_if bus();

    issue_ctrl #(.NUM_REGS(32), .MAX_INFLIGHT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .busy_vec  (busy_vec),
        .inflight  (inflight),
        .stall_cnt (stall_cnt),
        .err       (err)
    );

    int          checks = 0, errors = 0;
    int          q[$];            // destination of each outstanding long op (0 = no register)
    bit          m_err = 0, m_drain = 0;
    int unsigned m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (q[i]) if (q[i] != 0) b[q[i]] = 1'b1;
        return b;
    endfunction

    function automatic instr_t mk(bit lng, bit fn, bit wr, logic [4:0] rd,
                                  bit u1, logic [4:0] rs1, bit u2, logic [4:0] rs2);
        instr_t i;
        i.v = 1; i.fn = fn; i.lng = lng; i.wr = wr; i.rd = rd;
        i.u1 = u1; i.rs1 = rs1; i.u2 = u2; i.rs2 = rs2;
        return i;
    endfunction

    task automatic drive(input instr_t i, input bit fl, input bit rdy, input bit wbv, input logic [4:0] wbr);
        bus.dec_valid = i.v;   bus.dec_fence = i.fn;   bus.dec_long = i.lng;
        bus.dec_writes_rd = i.wr; bus.dec_uses_rs1 = i.u1; bus.dec_uses_rs2 = i.u2;
        bus.dec_rs1 = i.rs1;   bus.dec_rs2 = i.rs2;    bus.dec_rd = i.rd;
        flush = fl; bus.iss_ready = rdy; wb_valid = wbv; wb_rd = wbr;
    endtask

    task automatic model_reset();
        q.delete(); m_err = 0; m_drain = 0; m_stall = 0;
    endtask

    task automatic cycle(input instr_t i, input bit fl, input bit rdy, input bit wbv,
                         input logic [4:0] wbr, output bit fired);
        logic [31:0] b;
        bit hz, cap, exp_v;
        int k;
        @(negedge clk);
        drive(i, fl, rdy, wbv, wbr);
        #1;
        b   = m_busy();
        hz  = (i.u1 && i.rs1 != 0 && b[i.rs1]) || (i.u2 && i.rs2 != 0 && b[i.rs2]) ||
              (i.wr && i.rd != 0 && b[i.rd]);
        cap = i.lng && (q.size() == 4);
        if (m_drain)                  exp_v = i.v && i.fn && !fl && q.size() == 0;
        else if (i.v && i.fn && !fl)  exp_v = (q.size() == 0);
        else                          exp_v = i.v && !fl && !i.fn && !hz && !cap;
        fired = exp_v && rdy;
        check("iss_valid", {31'd0, bus.iss_valid}, {31'd0, exp_v});
        check("dec_ready", {31'd0, bus.dec_ready}, {31'd0, fired});
        check("busy_vec",  busy_vec, b);
        check("inflight",  {29'd0, inflight}, q.size());
        check("stall_cnt", stall_cnt, m_stall);
        check("err",       {31'd0, err}, {31'd0, m_err});
        @(posedge clk);
        if (!m_drain && i.v && i.fn && !fl && q.size() != 0) m_drain = 1;
        else if (m_drain && (fl || fired))                     m_drain = 0;
        if (i.v && !fired && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (wbv) begin
            if (q.size() == 0) m_err = 1;
            else begin
                k = -1;
                foreach (q[j]) if (q[j] == wbr && k < 0) k = j;
                if (k >= 0) q.delete(k); else void'(q.pop_front());
            end
        end
        if (fired && i.lng) q.push_back(i.wr ? int'(i.rd) : 0);
    endtask

    instr_t idle, cur;
    bit     f, have;

    initial begin
        idle = '0;
        drive(mk(0, 0, 1, 5'd3, 1, 5'd1, 0, 5'd0), 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
        check("rst_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_inflight", {29'd0, inflight}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        drive(idle, 0, 1, 0, 0);
        rst_n = 1'b1;

        // Load-use: stalls until the cycle after wb of x5
        cycle(mk(1, 0, 1, 5'd5, 1, 5'd1, 0, 5'd0), 0, 1, 0, 0, f);
        repeat (3) cycle(mk(0, 0, 1, 5'd6, 1, 5'd5, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 0, 1, 5'd6, 1, 5'd5, 0, 5'd0), 0, 1, 1, 5'd5, f);
        cycle(mk(0, 0, 1, 5'd6, 1, 5'd5, 0, 5'd0), 0, 1, 0, 0, f);
        // x0 long op and short op
        cycle(mk(1, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 0, 1, 5'd7, 0, 5'd0, 0, 5'd0), 0, 1, 1, 5'd0, f);
        cycle(idle, 0, 1, 0, 0, f);
        // Capacity
        for (int r = 1; r <= 4; r++) cycle(mk(1, 0, 1, 5'(r), 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(1, 0, 1, 5'd6, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 0, 1, 5'd7, 1, 5'd8, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(1, 0, 1, 5'd6, 0, 5'd0, 0, 5'd0), 0, 1, 1, 5'd1, f);
        cycle(mk(1, 0, 1, 5'd6, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        // Fence with two outstanding
        cycle(idle, 0, 1, 1, 5'd2, f);
        cycle(idle, 0, 1, 1, 5'd3, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 1, 5'd4, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 1, 5'd6, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 0, 1, 5'd9, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        // Flush blocks a hazard-free instruction
        cycle(mk(0, 0, 1, 5'd8, 1, 5'd9, 0, 5'd0), 1, 1, 0, 0, f);

        have = 0;
        for (int n = 0; n < 1500; n++) begin
            bit fl, wbv;
            logic [4:0] wbr;
            if (!have) begin
                cur.v   = ($urandom_range(0, 3) != 0);
                cur.fn  = ($urandom_range(0, 19) == 0);
                cur.lng = ($urandom_range(0, 4) < 2);
                cur.wr  = $urandom_range(0, 1);
                cur.u1  = $urandom_range(0, 1);
                cur.u2  = $urandom_range(0, 1);
                cur.rs1 = 5'($urandom_range(0, 7));
                cur.rs2 = 5'($urandom_range(0, 7));
                cur.rd  = 5'($urandom_range(0, 7));
                have = cur.v;
            end
            fl  = ($urandom_range(0, 24) == 0);
            wbv = (q.size() != 0) && ($urandom_range(0, 2) == 0);
            wbr = wbv ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
            cycle(cur, fl, ($urandom_range(0, 4) != 0), wbv, wbr, f);
            if (f || fl) have = 0;
        end
        while (q.size() != 0) cycle(idle, 0, 1, 1, 5'(q[0]), f);
        cycle(idle, 1, 1, 0, 0, f);

        // Same-cycle long fire to x9 and wb of x9; then wb underflow
        cycle(mk(1, 0, 1, 5'd3, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        @(negedge clk);
        drive(mk(1, 0, 1, 5'd9, 0, 5'd0, 0, 5'd0), 0, 1, 1, 5'd9);
        #1;
        check("x9_fire", {31'd0, bus.dec_ready}, 32'd1);
        @(negedge clk);
        drive(idle, 0, 1, 1, 5'd3);
        #1;
        check("x9_busy", busy_vec, 32'h0000_0208);
        check("x9_inflight", {29'd0, inflight}, 32'd1);
        @(negedge clk);
        #1;
        check("wb_to_zero", {29'd0, inflight}, 32'd0);
        check("err_before", {31'd0, err}, 32'd0);
        @(negedge clk);
        drive(idle, 0, 1, 0, 0);
        #1;
        check("err_set", {31'd0, err}, 32'd1);
        check("inflight_sat0", {29'd0, inflight}, 32'd0);
        @(negedge clk);
        #1;
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset in DRAIN with three outstanding
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int r = 1; r <= 3; r++) cycle(mk(1, 0, 1, 5'(r), 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
        check("arst_busy", busy_vec, 32'd0);
        check("arst_inflight", {29'd0, inflight}, 32'd0);
        check("arst_stall", stall_cnt, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(mk(0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0), 0, 1, 0, 0, f);
        cycle(idle, 0, 1, 1, 5'd2, f);
        cycle(idle, 0, 1, 0, 0, f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
